// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among CH_NUM byte sources.
// Sequences the core's start/busy handshake and flags a sticky error if busy never rises.
module uart_tx_arbiter #(
    parameter int CH_NUM   = 4,
    parameter int BUSY_TMO = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH_NUM-1:0]     req,
    input  logic [8*CH_NUM-1:0]   req_data,
    output logic [CH_NUM-1:0]     ack,
    output logic [2:0]            grant_id,
    output logic                  busy,
    output logic                  tmo_err,
    input  logic                  clr_err,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [4:0] TMO_LIMIT = 5'(BUSY_TMO);
    localparam logic [2:0] LAST_RST  = 3'(CH_NUM - 1);

    state_t            state_reg;
    logic [2:0]        last_reg;
    logic [4:0]        cnt_reg;
    logic [CH_NUM-1:0] ack_reg;
    logic [2:0]        grant_id_reg;
    logic              busy_reg;
    logic              tmo_err_reg;
    logic              tx_start_reg;
    logic [7:0]        tx_data_reg;

    // Channels are padded out to 8 so a 3-bit index always lands on a real entry.
    logic [7:0]        req_ext;
    logic [7:0]        req_bytes [0:7];
    logic [7:0]        ack_dec;
    logic [2:0]        win_id;
    logic              win_valid;
    int                idx;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < CH_NUM) begin : g_real
                assign req_ext[gi]   = req[gi];
                assign req_bytes[gi] = req_data[8*gi +: 8];
            end else begin : g_absent
                assign req_ext[gi]   = 1'b0;
                assign req_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    // Scan offsets from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        win_id    = 3'd0;
        win_valid = 1'b0;
        idx       = 0;
        for (int off = CH_NUM; off >= 1; off--) begin
            idx = int'(last_reg) + off;
            if (idx >= CH_NUM) begin
                idx = idx - CH_NUM;
            end
            if (req_ext[3'(idx)]) begin
                win_id    = 3'(idx);
                win_valid = 1'b1;
            end
        end
    end

    assign ack_dec = 8'd1 << grant_id_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_reg     <= LAST_RST;
            cnt_reg      <= 5'd0;
            ack_reg      <= '0;
            grant_id_reg <= 3'd0;
            busy_reg     <= 1'b0;
            tmo_err_reg  <= 1'b0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            tx_start_reg <= 1'b0;
            ack_reg      <= '0;
            if (clr_err) begin
                tmo_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (!tx_busy && win_valid) begin
                        state_reg    <= START;
                        busy_reg     <= 1'b1;
                        grant_id_reg <= win_id;
                        tx_data_reg  <= req_bytes[win_id];
                    end
                end
                START: begin
                    tx_start_reg <= 1'b1;
                    ack_reg      <= ack_dec[CH_NUM-1:0];
                    cnt_reg      <= 5'd0;
                    state_reg    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // The error is flagged one cycle before leaving, so busy drops a cycle later.
                    if (cnt_reg > TMO_LIMIT) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        last_reg  <= grant_id_reg;
                    end else if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        if (cnt_reg == TMO_LIMIT) begin
                            tmo_err_reg <= 1'b1;
                        end
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        last_reg  <= grant_id_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ack      = ack_reg;
    assign grant_id = grant_id_reg;
    assign busy     = busy_reg;
    assign tmo_err  = tmo_err_reg;
    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grants, round-robin order, timeout and resets.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [2:0]  grant_id;
    logic        busy;
    logic        tmo_err;
    logic        clr_err;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int ack_cnt = 0;
    int snap;

    uart_tx_arbiter #(.CH_NUM(4), .BUSY_TMO(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .tmo_err  (tmo_err),
        .clr_err  (clr_err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_start === 1'b1) start_cnt++;
        if (ack !== 4'b0000) ack_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_start", 32'(tx_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_data", 32'(tx_data), 32'h0);
        chk("rst_tmo", 32'(tmo_err), 32'h0);
        tick();
        chk("rst_hold_ack", 32'(ack), 32'h0);
        reset = 1'b0;
        $display("reset applied and released");
    endtask

    // One full grant: IDLE decision edge, START, tx_busy for `hold` cycles, return to IDLE.
    task automatic serve(input logic [2:0] ch, input logic [7:0] byt, input int hold, input logic drop);
        tick();
        chk("grant_busy", 32'(busy), 32'h1);
        chk("grant_id", 32'(grant_id), 32'(ch));
        chk("pre_start", 32'(tx_start), 32'h0);
        tick();
        chk("tx_start", 32'(tx_start), 32'h1);
        chk("ack", 32'(ack), 32'(4'b0001 << ch));
        chk("tx_data", 32'(tx_data), 32'(byt));
        if (drop) req[ch] = 1'b0;
        tick();
        chk("ack_pulse", 32'(ack), 32'h0);
        tx_busy = 1'b1;
        repeat (hold) tick();
        chk("busy_held", 32'(busy), 32'h1);
        tx_busy = 1'b0;
        tick();
        chk("busy_drop", 32'(busy), 32'h0);
        $display("grant ch=%0d data=%02h ack=%b", ch, byt, 4'b0001 << ch);
    endtask

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h33_32_31_30;
        clr_err  = 1'b0;
        tx_busy  = 1'b0;
        #2;
        do_reset();

        // Single request on channel 2
        req_data = 32'h13_41_11_10;
        req      = 4'b0100;
        snap     = start_cnt;
        serve(3'd2, 8'h41, 10, 1'b1);
        tick();
        chk("single_starts", 32'(start_cnt - snap), 32'h1);
        chk("single_idle", 32'(busy), 32'h0);

        // All four requesting continuously
        do_reset();
        req_data = 32'h33_32_31_30;
        req      = 4'b1111;
        serve(3'd0, 8'h30, 2, 1'b0);
        serve(3'd1, 8'h31, 2, 1'b0);
        serve(3'd2, 8'h32, 2, 1'b0);
        serve(3'd3, 8'h33, 2, 1'b0);
        serve(3'd0, 8'h30, 2, 1'b1);
        req = 4'b0000;

        // Fairness after reset
        do_reset();
        req_data = 32'hD3_C2_B1_A0;
        req      = 4'b1001;
        serve(3'd0, 8'hA0, 3, 1'b1);
        serve(3'd3, 8'hD3, 3, 1'b1);
        req = 4'b1001;
        serve(3'd0, 8'hA0, 3, 1'b1);
        req = 4'b0000;

        // Timeout with tx_busy held low
        do_reset();
        req = 4'b0001;
        tick();
        chk("tmo_grant", 32'(grant_id), 32'h0);
        tick();
        chk("tmo_start", 32'(tx_start), 32'h1);
        req = 4'b0000;
        repeat (4) tick();
        chk("tmo_early", 32'(tmo_err), 32'h0);
        tick();
        chk("tmo_set", 32'(tmo_err), 32'h1);
        chk("tmo_busy", 32'(busy), 32'h1);
        tick();
        chk("tmo_idle", 32'(busy), 32'h0);
        chk("tmo_sticky", 32'(tmo_err), 32'h1);
        $display("timeout observed tmo_err=%b", tmo_err);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("tmo_clear", 32'(tmo_err), 32'h0);
        $display("clr_err applied tmo_err=%b", tmo_err);

        // Timeout and clr_err in the same cycle: set wins
        req = 4'b0001;
        tick();
        chk("tmo2_grant", 32'(grant_id), 32'h0);
        tick();
        req = 4'b0000;
        repeat (4) tick();
        chk("tmo2_early", 32'(tmo_err), 32'h0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("tmo2_setwins", 32'(tmo_err), 32'h1);
        tick();
        chk("tmo2_idle", 32'(busy), 32'h0);
        $display("timeout with clr_err tmo_err=%b", tmo_err);

        // External busy blocks the grant
        tx_busy  = 1'b1;
        req_data = 32'h00_00_00_5A;
        req      = 4'b0001;
        snap     = start_cnt;
        repeat (4) tick();
        chk("ext_busy_idle", 32'(busy), 32'h0);
        chk("ext_no_start", 32'(start_cnt - snap), 32'h0);
        tx_busy = 1'b0;
        serve(3'd0, 8'h5A, 3, 1'b1);
        $display("external busy released, grant followed");

        // Reset during WAIT_DONE, then a pending request on channel 1
        req_data = 32'h00_00_55_00;
        req      = 4'b0010;
        tick();
        tick();
        chk("wd_start", 32'(tx_start), 32'h1);
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        chk("wd_busy", 32'(busy), 32'h1);
        chk("wd_tmo_before", 32'(tmo_err), 32'h1);
        snap = ack_cnt;
        do_reset();
        tx_busy = 1'b0;
        chk("wd_no_ack", 32'(ack_cnt - snap), 32'h0);
        serve(3'd1, 8'h55, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
